// File: rtl/pwm_pkg.sv
// Shared types, defaults and helpers for the multi-channel PWM generator.
package pwm_pkg;

  localparam int unsigned CBITS_DEF = 19;

  typedef logic [CBITS_DEF-1:0] cnt_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Number of bits needed to hold the value n itself (never less than 1).
  // The channel index is sized with this, so it can also encode N_CH and
  // out-of-range targets such as wr_chan=5 on a 4-channel build are visible.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned b = 1; b < 32; b++) begin
      if ((n >> b) != 0) w = b + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pwm_multi_gen_if.sv
// Duty write port: valid/ready handshake carrying channel index and duty.
interface pwm_multi_gen_if
  import pwm_pkg::*;
#(
  parameter int unsigned CHW   = 3,
  parameter int unsigned CBITS = CBITS_DEF
);
  logic             wr_valid;
  logic             wr_ready;
  logic [CHW-1:0]   wr_chan;
  logic [CBITS-1:0] wr_duty;

  modport master (output wr_valid, output wr_chan, output wr_duty, input wr_ready);
  modport slave  (input wr_valid, input wr_chan, input wr_duty, output wr_ready);
endinterface

// File: rtl/pwm_chan.sv
// One PWM channel: shadow duty, active duty reloaded at period boundaries
// (with same-cycle write forwarding), and a registered compare output.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int unsigned CBITS = CBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             wr_hit_i,
  input  logic [CBITS-1:0] wr_duty_i,
  input  logic [CBITS-1:0] cnt_i,
  output logic             pwm_o
);

  logic [CBITS-1:0] shadow_q;
  logic [CBITS-1:0] active_q;
  logic             pwm_q;

  // Shadow capture, active reload at wrap/idle, and output compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      if (wr_hit_i) shadow_q <= wr_duty_i;
      // A write landing on the load cycle goes straight into active.
      if (load_i) active_q <= wr_hit_i ? wr_duty_i : shadow_q;
      pwm_q <= en_i && (cnt_i < active_q);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// N-channel PWM generator: shared period counter, double-buffered duty
// registers per channel, valid/ready duty write port with sticky range error.
// Build option: define PWM_CENTER_ALIGNED_EN for an up/down (centre-aligned)
// counter; otherwise the counter is edge-aligned.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CBITS = CBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CBITS-1:0] period,
  pwm_multi_gen_if.slave   wr,
  output logic [N_CH-1:0]  pwm_out,
  output logic             wrap,
  output logic             wr_err
);

  localparam int unsigned CHW = clog2_min1(N_CH);

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [CBITS-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic             wr_ready_q;
  logic             wr_err_q;
  logic             load;
  logic             wr_fire;
  logic             wr_oob;
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  pwm_bits;

`ifdef PWM_CENTER_ALIGNED_EN
  dir_e dir_q, dir_d;
`endif

  assign wr_fire = wr.wr_valid && wr_ready_q;
  assign wr_oob  = (wr.wr_chan >= CHW'(N_CH));

  // Counter next state: period boundary detection, reload strobe, wrap pulse.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    load     = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
    dir_d    = dir_q;
`endif
    if (!en) begin
      cnt_d    = '0;
      period_d = period;
      load     = 1'b1;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_d    = DIR_UP;
`endif
    end else begin
`ifdef PWM_CENTER_ALIGNED_EN
      if (period_q == '0) begin
        cnt_d    = '0;
        wrap_d   = 1'b1;
        period_d = period;
        load     = 1'b1;
        dir_d    = DIR_UP;
      end else begin
        unique case (dir_q)
          DIR_UP: begin
            if (cnt_q == period_q) begin
              dir_d = DIR_DOWN;
              cnt_d = cnt_q - CBITS'(1);
            end else begin
              cnt_d = cnt_q + CBITS'(1);
            end
          end
          DIR_DOWN: begin
            // Turn at zero is the period boundary; zero is visited once.
            if (cnt_q == '0) begin
              dir_d    = DIR_UP;
              cnt_d    = CBITS'(1);
              wrap_d   = 1'b1;
              period_d = period;
              load     = 1'b1;
            end else begin
              cnt_d = cnt_q - CBITS'(1);
            end
          end
          default: dir_d = DIR_UP;
        endcase
      end
`else
      if (cnt_q == period_q) begin
        cnt_d    = '0;
        wrap_d   = 1'b1;
        period_d = period;
        load     = 1'b1;
      end else begin
        cnt_d = cnt_q + CBITS'(1);
      end
`endif
    end
  end

  // Counter, period, direction, handshake ready and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      period_q   <= '0;
      wrap_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      wr_err_q   <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_q      <= DIR_UP;
`endif
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      wrap_q     <= wrap_d;
      wr_ready_q <= 1'b1;
      if (wr_fire && wr_oob) wr_err_q <= 1'b1;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_q      <= dir_d;
`endif
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_hit[i] = wr_fire && (wr.wr_chan == CHW'(i));

    pwm_chan #(
      .CBITS (CBITS)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en),
      .load_i    (load),
      .wr_hit_i  (wr_hit[i]),
      .wr_duty_i (wr.wr_duty),
      .cnt_i     (cnt_q),
      .pwm_o     (pwm_bits[i])
    );
  end

  assign wr.wr_ready = wr_ready_q;
  assign pwm_out     = pwm_bits;
  assign wrap        = wrap_q;
  assign wr_err      = wr_err_q;

endmodule
